charlieplex_pwm_scheduler: RTL and testbench
============================================

// Module: charlieplex_pwm_scheduler
// PURPOSE
//  Brightness scheduler feeding a charlieplexer (LED index + enable inputs).
//  - Scans PIXELCOUNT LEDs one at a time.
//  - Per-pixel PWM, BRIGHTBITS deep, with dead-time blanking between pixels against ghosting.
//  - Double-buffered framebuffer: writes go to the back buffer, which is swapped to the front only at frame end.
// PARAMETERS
//  PIXELCOUNT  12  number of LEDs; INDEXBITS = $clog2(PIXELCOUNT+1)
//  BRIGHTBITS  4   brightness width; PWM period P = 2**BRIGHTBITS-1 cycles
//  DEADTIME    1   blanking cycles before each pixel (>=1)
// PORTS
//  pixelclock  in   1           single clock; all logic on rising edge
//  rst_n       in   1           reset, synchronous, active-low
//  enable      in   1           global display enable
//  wr_valid    in   1           back-buffer write request
//  wr_ready    out  1           write accepted when wr_valid&&wr_ready
//  wr_addr     in   INDEXBITS   pixel index to write
//  wr_data     in   BRIGHTBITS  brightness, 0=off, P=full
//  swap_req    in   1           request back->front copy at next frame end (level, sampled)
//  swap_ack    out  1           1-cycle pulse when swap performed
//  frame_start out  1           1-cycle pulse on first cycle of pixel 0
//  led_index   out  INDEXBITS   to charlieplexer index input
//  led_enable  out  1           to charlieplexer enable input
// BEHAVIOUR
//  Reset: both buffers=0, state IDLE, pixel=0, led_index=0, led_enable=0, swap_ack=0,
//   frame_start=0, swap_pending=0, wr_ready=0 while rst_n=0 and 1 afterwards.
//  FSM IDLE -> BLANK -> SHOW -> BLANK ... :
//   IDLE: led_enable=0; leave when enable=1 -> BLANK with pixel=0, frame_start=1.
//   BLANK: DEADTIME cycles, led_index=pixel, led_enable=0 -> SHOW.
//   SHOW: P cycles; slot counter s=0..P-1; led_enable = (s < front[pixel]).
//    On the last slot: pixel++ -> BLANK.
//    If pixel==PIXELCOUNT-1: frame end, pixel=0 -> BLANK, frame_start=1.
//  Frame length = PIXELCOUNT*(DEADTIME+P) cycles, e.g. 12*(1+15)=192.
//  Outputs are registered: led_index/led_enable change 1 cycle after the state/slot change.
//  Writes:
//   - 1-cycle accept; back[wr_addr]<=wr_data.
//   - wr_addr>=PIXELCOUNT: handshake completes, data dropped.
//  Swap:
//   - swap_req=1 sets swap_pending; while pending, wr_ready=0.
//   - Write and swap_req in the same cycle: the write is accepted first, then the swap goes pending.
//   - At frame end (or any cycle in IDLE): front<=back, swap_ack pulses, swap_pending clears.
//   - Back buffer keeps its contents after a swap.
//   - The swap takes effect starting with the new frame's pixel 0.
//  Enable drop mid-frame: led_enable=0 next cycle, state -> IDLE, pixel/slot reset.
//   Re-enable restarts at pixel 0.
//  rst_n low mid-frame: full reset on that edge; both buffers cleared.
// CONFIGURATION
//  CHARLIEPLEX_SKIP_DARK_EN defined:
//   - A pixel with front[pixel]==0 takes exactly 1 cycle (led_enable=0) instead of DEADTIME+P.
//   - Boosts duty cycle on sparse images.
//   - All-dark frame = PIXELCOUNT cycles.
//  Undefined: every pixel takes DEADTIME+P cycles regardless of value.
// STRUCTURE
//  Shared package charlieplex_pkg:
//   - state encoding IDLE/BLANK/SHOW
//   - index-width helper function for INDEXBITS
//   - PWM-period constant helper
//  Sub-module charlieplex_framebuffer: front/back register arrays, write port,
//   swap strobe, combinational front read by pixel index.
// TESTING
//  1 Reset, enable=1, all pixels 0 -> led_enable never 1; frame_start every 192 cycles.
//  2 Write pixel 3=15, pixel 5=7, swap_req pulse -> swap_ack at frame end; next frame:
//    pixel3 enable high 15 cycles, pixel5 high 7 cycles, both after 1 blank cycle, led_index 3/5.
//  3 swap_req and wr_valid(addr 2,data 4) same cycle -> write lands in back,
//    wr_ready=0 until swap_ack, then front[2]=4.
//  4 enable 1->0 during SHOW of pixel 6 -> led_enable 0 next cycle; re-enable -> frame_start,
//    led_index=0.
//  5 wr_addr=12 (PIXELCOUNT=12) -> accepted, no buffer change; rst_n low mid-SHOW ->
//    all outputs at reset values next cycle.
//  6 With CHARLIEPLEX_SKIP_DARK_EN, only pixel 0=15 -> frame length 16+11=27 cycles.

Source files
------------

// File: rtl/charlieplex_pwm_scheduler_pkg.sv
// Shared types and sizing helpers for the charlieplex PWM scheduler.
package charlieplex_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  function automatic int index_bits(input int pixel_count);
    return $clog2(pixel_count + 1);
  endfunction

  function automatic int pwm_period(input int bright_bits);
    return (1 << bright_bits) - 1;
  endfunction

endpackage

// File: rtl/charlieplex_pwm_scheduler_if.sv
// Framebuffer write port and swap handshake of the charlieplex PWM scheduler.
interface charlieplex_pwm_scheduler_if #(
  parameter int INDEXBITS  = 4,
  parameter int BRIGHTBITS = 4
) ();
  logic                  wr_valid;
  logic                  wr_ready;
  logic [INDEXBITS-1:0]  wr_addr;
  logic [BRIGHTBITS-1:0] wr_data;
  logic                  swap_req;
  logic                  swap_ack;

  modport master (output wr_valid, wr_addr, wr_data, swap_req, input wr_ready, swap_ack);
  modport slave  (input wr_valid, wr_addr, wr_data, swap_req, output wr_ready, swap_ack);
endinterface

// File: rtl/charlieplex_pwm_scheduler_framebuffer.sv
// Double-buffered brightness store: writes land in back, swap copies back to front.
module charlieplex_framebuffer
  import charlieplex_pkg::*;
#(
  parameter int PIXELCOUNT = 12,
  parameter int BRIGHTBITS = 4,
  parameter int INDEXBITS  = index_bits(PIXELCOUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [INDEXBITS-1:0]  wr_addr,
  input  logic [BRIGHTBITS-1:0] wr_data,
  input  logic                  swap,
  input  logic [INDEXBITS-1:0]  rd_addr,
  output logic [BRIGHTBITS-1:0] rd_data
);
  localparam logic [INDEXBITS-1:0]  PIX_COUNT = INDEXBITS'(PIXELCOUNT);
  localparam logic [BRIGHTBITS-1:0] DARK      = {BRIGHTBITS{1'b0}};

  logic [BRIGHTBITS-1:0] back_r  [PIXELCOUNT];
  logic [BRIGHTBITS-1:0] front_r [PIXELCOUNT];

  // Buffer storage; out-of-range write addresses are silently dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PIXELCOUNT; i++) begin
        back_r[i]  <= DARK;
        front_r[i] <= DARK;
      end
    end else begin
      if (wr_en && (wr_addr < PIX_COUNT)) begin
        back_r[wr_addr] <= wr_data;
      end
      if (swap) begin
        for (int i = 0; i < PIXELCOUNT; i++) begin
          front_r[i] <= back_r[i];
        end
      end
    end
  end

  // Front read for the pixel currently being scanned.
  always_comb begin
    if (rd_addr < PIX_COUNT) begin
      rd_data = front_r[rd_addr];
    end else begin
      rd_data = DARK;
    end
  end
endmodule

// File: rtl/charlieplex_pwm_scheduler.sv
// Scans PIXELCOUNT LEDs with per-pixel PWM and dead-time blanking.
// Define CHARLIEPLEX_SKIP_DARK_EN to collapse dark pixels to a single cycle.
module charlieplex_pwm_scheduler
  import charlieplex_pkg::*;
#(
  parameter int PIXELCOUNT = 12,
  parameter int BRIGHTBITS = 4,
  parameter int DEADTIME   = 1,
  parameter int INDEXBITS  = index_bits(PIXELCOUNT)
) (
  input  logic                       pixelclock,
  input  logic                       rst_n,
  input  logic                       enable,
  charlieplex_pwm_scheduler_if.slave bus,
  output logic                       frame_start,
  output logic [INDEXBITS-1:0]       led_index,
  output logic                       led_enable
);
  localparam int P  = pwm_period(BRIGHTBITS);
  localparam int BW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [BRIGHTBITS-1:0] LAST_SLOT  = BRIGHTBITS'(P - 1);
  localparam logic [BRIGHTBITS-1:0] ZERO_SLOT  = {BRIGHTBITS{1'b0}};
  localparam logic [INDEXBITS-1:0]  LAST_PIXEL = INDEXBITS'(PIXELCOUNT - 1);
  localparam logic [INDEXBITS-1:0]  ZERO_PIX   = {INDEXBITS{1'b0}};
  localparam logic [BW-1:0]         LAST_BLANK = BW'(DEADTIME - 1);
  localparam logic [BW-1:0]         ZERO_BLANK = {BW{1'b0}};
`ifdef CHARLIEPLEX_SKIP_DARK_EN
  localparam logic SKIP_DARK = 1'b1;
`else
  localparam logic SKIP_DARK = 1'b0;
`endif

  state_t                state_r, state_s;
  logic [INDEXBITS-1:0]  pixel_r, pixel_s;
  logic [BRIGHTBITS-1:0] slot_r, slot_s;
  logic [BW-1:0]         blank_r, blank_s;
  logic                  advance_s, frame_start_s, frame_end_s;
  logic                  swap_pending_r, swap_pending_s, swap_do_s, wr_accept_s;
  logic                  wr_ready_r, swap_ack_r, frame_start_r, led_enable_r, led_enable_s;
  logic [INDEXBITS-1:0]  led_index_r, led_index_s;
  logic [BRIGHTBITS-1:0] front_px_s;

  charlieplex_framebuffer #(
    .PIXELCOUNT(PIXELCOUNT), .BRIGHTBITS(BRIGHTBITS), .INDEXBITS(INDEXBITS)
  ) u_fb (
    .clk(pixelclock), .rst_n(rst_n), .wr_en(wr_accept_s), .wr_addr(bus.wr_addr),
    .wr_data(bus.wr_data), .swap(swap_do_s), .rd_addr(pixel_r), .rd_data(front_px_s)
  );

  // A write in the same cycle as swap_req is taken before the swap goes pending.
  assign wr_accept_s    = bus.wr_valid && wr_ready_r;
  assign swap_do_s      = swap_pending_r && (frame_end_s || (state_r == IDLE));
  assign swap_pending_s = swap_do_s ? 1'b0 : (swap_pending_r || bus.swap_req);

  // Scan sequencer: next state, pixel and slot.
  always_comb begin
    state_s       = state_r;
    pixel_s       = pixel_r;
    slot_s        = slot_r;
    blank_s       = blank_r;
    advance_s     = 1'b0;
    frame_start_s = 1'b0;
    frame_end_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable) begin
          state_s       = BLANK;
          frame_start_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      BLANK: begin
        if (!enable) begin
          state_s = IDLE;
        end else if (SKIP_DARK && (front_px_s == ZERO_SLOT)) begin
          advance_s = 1'b1;
        end else if (blank_r == LAST_BLANK) begin
          state_s = SHOW;
          slot_s  = ZERO_SLOT;
        end else begin
          blank_s = blank_r + 1'b1;
        end
      end
      SHOW: begin
        if (!enable) begin
          state_s = IDLE;
        end else if (slot_r == LAST_SLOT) begin
          advance_s = 1'b1;
        end else begin
          slot_s = slot_r + 1'b1;
        end
      end
      default: state_s = IDLE;
    endcase
    if (state_s == IDLE || (state_r == IDLE)) begin
      pixel_s = ZERO_PIX;
      slot_s  = ZERO_SLOT;
      blank_s = ZERO_BLANK;
    end else if (advance_s) begin
      state_s = BLANK;
      blank_s = ZERO_BLANK;
      slot_s  = ZERO_SLOT;
      if (pixel_r == LAST_PIXEL) begin
        pixel_s       = ZERO_PIX;
        frame_end_s   = 1'b1;
        frame_start_s = 1'b1;
      end else begin
        pixel_s = pixel_r + 1'b1;
      end
    end else begin
      frame_end_s = 1'b0;
    end
  end

  // LED drive derived from the current scan position.
  always_comb begin
    led_enable_s = enable && (state_r == SHOW) && (slot_r < front_px_s);
    if (state_r == IDLE) begin
      led_index_s = ZERO_PIX;
    end else begin
      led_index_s = pixel_r;
    end
  end

  // State and registered outputs.
  always_ff @(posedge pixelclock) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      pixel_r        <= ZERO_PIX;
      slot_r         <= ZERO_SLOT;
      blank_r        <= ZERO_BLANK;
      swap_pending_r <= 1'b0;
      wr_ready_r     <= 1'b0;
      swap_ack_r     <= 1'b0;
      frame_start_r  <= 1'b0;
      led_enable_r   <= 1'b0;
      led_index_r    <= ZERO_PIX;
    end else begin
      state_r        <= state_s;
      pixel_r        <= pixel_s;
      slot_r         <= slot_s;
      blank_r        <= blank_s;
      swap_pending_r <= swap_pending_s;
      wr_ready_r     <= !swap_pending_s;
      swap_ack_r     <= swap_do_s;
      frame_start_r  <= frame_start_s;
      led_enable_r   <= led_enable_s;
      led_index_r    <= led_index_s;
    end
  end

  assign bus.wr_ready = wr_ready_r;
  assign bus.swap_ack = swap_ack_r;
  assign frame_start  = frame_start_r;
  assign led_index    = led_index_r;
  assign led_enable   = led_enable_r;
endmodule

// File: tb/tb_charlieplex_pwm_scheduler.sv
// Directed bench for charlieplex_pwm_scheduler (12 pixels, 4-bit PWM, 1 dead cycle).
module tb_charlieplex_pwm_scheduler;
  localparam int PIXELCOUNT = 12;
  localparam int BRIGHTBITS = 4;
  localparam int DEADTIME   = 1;
  localparam int INDEXBITS  = 4;
  localparam int P          = 15;

  typedef struct {
    int addr;
    int data;
    int exp_on;
  } vec_t;

  logic                 pixelclock = 1'b0;
  logic                 rst_n      = 1'b0;
  logic                 enable     = 1'b0;
  logic                 frame_start;
  logic                 led_enable;
  logic [INDEXBITS-1:0] led_index;

  int errors = 0;
  int checks = 0;
  int on_cnt [16];
  int back_m [PIXELCOUNT];
  int front_m[PIXELCOUNT];
  vec_t vecs[6];

  charlieplex_pwm_scheduler_if #(.INDEXBITS(INDEXBITS), .BRIGHTBITS(BRIGHTBITS)) bus ();

  charlieplex_pwm_scheduler #(
    .PIXELCOUNT(PIXELCOUNT), .BRIGHTBITS(BRIGHTBITS), .DEADTIME(DEADTIME)
  ) u_dut (
    .pixelclock(pixelclock), .rst_n(rst_n), .enable(enable), .bus(bus.slave),
    .frame_start(frame_start), .led_index(led_index), .led_enable(led_enable)
  );

  always #5 pixelclock = ~pixelclock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pixelclock);
    #1;
  endtask

  function automatic int frame_len();
    int n = 0;
    for (int p = 0; p < PIXELCOUNT; p++) begin
`ifdef CHARLIEPLEX_SKIP_DARK_EN
      n += (front_m[p] == 0) ? 1 : (DEADTIME + P);
`else
      n += DEADTIME + P;
`endif
    end
    return n;
  endfunction

  // Called on a frame_start sample; counts lit cycles per index up to the next frame_start.
  task automatic check_frame(input string name);
    int len = 0;
    for (int i = 0; i < 16; i++) on_cnt[i] = 0;
    do begin
      step();
      len++;
      if (led_enable) on_cnt[led_index]++;
    end while (!frame_start && len < 1000);
    check({name, "_len"}, len, frame_len());
    for (int p = 0; p < PIXELCOUNT; p++) begin
      check($sformatf("%s_on%0d", name, p), on_cnt[p], front_m[p]);
    end
  endtask

  task automatic wait_fs(input string name, input int bound);
    int n = 0;
    while (!frame_start && n < bound) begin
      step();
      n++;
    end
    check(name, int'(frame_start), 1);
  endtask

  task automatic write_px(input int addr, input int data);
    int n = 0;
    while (!bus.wr_ready && n < 1000) begin
      step();
      n++;
    end
    check($sformatf("wr_ready_a%0d", addr), int'(bus.wr_ready), 1);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 4'(addr);
    bus.wr_data  = 4'(data);
    step();
    bus.wr_valid = 1'b0;
    if (addr < PIXELCOUNT) back_m[addr] = data;
  endtask

  task automatic swap_and_wait(input string name, input int bound);
    int n = 0;
    bus.swap_req = 1'b1;
    step();
    bus.swap_req = 1'b0;
    check({name, "_ready_low"}, int'(bus.wr_ready), 0);
    while (!bus.swap_ack && n < bound) begin
      step();
      n++;
    end
    check({name, "_ack"}, int'(bus.swap_ack), 1);
    for (int p = 0; p < PIXELCOUNT; p++) front_m[p] = back_m[p];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    vecs[0] = '{addr: 3,  data: 15, exp_on: 15};
    vecs[1] = '{addr: 5,  data: 7,  exp_on: 7};
    vecs[2] = '{addr: 0,  data: 1,  exp_on: 1};
    vecs[3] = '{addr: 6,  data: 10, exp_on: 10};
    vecs[4] = '{addr: 11, data: 15, exp_on: 15};
    vecs[5] = '{addr: 12, data: 9,  exp_on: 0};
    for (int p = 0; p < PIXELCOUNT; p++) begin
      back_m[p]  = 0;
      front_m[p] = 0;
    end
    bus.wr_valid = 1'b0;
    bus.wr_addr  = 4'd0;
    bus.wr_data  = 4'd0;
    bus.swap_req = 1'b0;

    // reset values
    step();
    step();
    check("rst_led_enable", int'(led_enable), 0);
    check("rst_led_index", int'(led_index), 0);
    check("rst_frame_start", int'(frame_start), 0);
    check("rst_swap_ack", int'(bus.swap_ack), 0);
    check("rst_wr_ready", int'(bus.wr_ready), 0);
    rst_n = 1'b1;
    step();
    check("post_rst_wr_ready", int'(bus.wr_ready), 1);

    // all-dark frames
    enable = 1'b1;
    wait_fs("first_frame_start", 10);
    check_frame("dark1");
    check_frame("dark2");

    // table image, swapped in at frame end
    for (int i = 0; i < 6; i++) write_px(vecs[i].addr, vecs[i].data);
    swap_and_wait("swap_img", 600);
    check("swap_at_frame_end", int'(frame_start), 1);
    check_frame("img");
    for (int i = 0; i < 6; i++) begin
      check($sformatf("tbl_on_a%0d", vecs[i].addr), on_cnt[vecs[i].addr], vecs[i].exp_on);
    end

    // write and swap_req in the same cycle
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 4'd2;
    bus.wr_data  = 4'd4;
    bus.swap_req = 1'b1;
    step();
    bus.wr_valid = 1'b0;
    bus.swap_req = 1'b0;
    back_m[2] = 4;
    check("wr_swap_ready_low", int'(bus.wr_ready), 0);
    n = 0;
    bad = 0;
    while (!bus.swap_ack && n < 600) begin
      if (bus.wr_ready) bad++;
      step();
      n++;
    end
    check("ready_low_until_ack", bad, 0);
    check("wr_swap_ack", int'(bus.swap_ack), 1);
    for (int p = 0; p < PIXELCOUNT; p++) front_m[p] = back_m[p];
    check_frame("wr_swap");
    check("pixel2_on", on_cnt[2], 4);
    check("pixel3_kept", on_cnt[3], 15);

    // enable drop during pixel 6, swap while idle, re-enable
    n = 0;
    while (!(led_enable && led_index == 4'd6) && n < 400) begin
      step();
      n++;
    end
    check("reach_pixel6", int'(led_index), 6);
    enable = 1'b0;
    step();
    check("drop_led_enable", int'(led_enable), 0);
    step();
    check("idle_led_enable", int'(led_enable), 0);
    check("idle_frame_start", int'(frame_start), 0);
    write_px(1, 5);
    swap_and_wait("idle_swap", 4);
    enable = 1'b1;
    step();
    check("reenable_frame_start", int'(frame_start), 1);
    check("reenable_led_index", int'(led_index), 0);
    check_frame("reenable");

    // reset mid-SHOW
    n = 0;
    while (!led_enable && n < 400) begin
      step();
      n++;
    end
    check("lit_before_reset", int'(led_enable), 1);
    rst_n = 1'b0;
    step();
    check("mid_rst_led_enable", int'(led_enable), 0);
    check("mid_rst_led_index", int'(led_index), 0);
    check("mid_rst_frame_start", int'(frame_start), 0);
    check("mid_rst_swap_ack", int'(bus.swap_ack), 0);
    check("mid_rst_wr_ready", int'(bus.wr_ready), 0);
    for (int p = 0; p < PIXELCOUNT; p++) begin
      back_m[p]  = 0;
      front_m[p] = 0;
    end
    rst_n = 1'b1;
    step();
    wait_fs("post_rst_frame_start", 10);
    check_frame("cleared");

    // single lit pixel 0 (27-cycle frame when dark pixels are skipped)
    write_px(0, 15);
    swap_and_wait("single", 600);
    check_frame("single");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
